// File: rtl/riscv_enc_pkg.sv
// rtl/riscv_enc_pkg.sv - RV32I format codes, opcode constants and writer FSM states
package riscv_enc_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_S   = 7'h23;
  localparam logic [6:0] OP_B   = 7'h63;
  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_JAL = 7'h6F;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/instr_field_packer.sv
// rtl/instr_field_packer.sv - combinational RV32I field packer, fmt + fields -> instruction word
module instr_field_packer
  import riscv_enc_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [2:0]  i_func3,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [6:0]  i_func7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_instr,
  output logic        o_legal
);

  always_comb begin
    o_instr = 32'h0;
    o_legal = 1'b1;
    case (i_fmt)
      FMT_R: o_instr = {i_func7, i_rs2, i_rs1, i_func3, i_rd, i_opcode};
      FMT_I: o_instr = {i_imm[11:0], i_rs1, i_func3, i_rd, i_opcode};
      FMT_S: o_instr = {i_imm[11:5], i_rs2, i_rs1, i_func3, i_imm[4:0], i_opcode};
      // B and J carry byte offsets; bit 0 is implicitly zero and dropped
      FMT_B: o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_func3,
                        i_imm[4:1], i_imm[11], i_opcode};
      FMT_U: o_instr = {i_imm[31:12], i_rd, i_opcode};
      FMT_J: o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_assembler_writer.sv
// rtl/instr_assembler_writer.sv - packs field tuples into instruction words and streams them with byte addresses
module instr_assembler_writer
  import riscv_enc_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [2:0]    i_in_fmt,
  input  logic [6:0]    i_in_opcode,
  input  logic [4:0]    i_in_rd,
  input  logic [2:0]    i_in_func3,
  input  logic [4:0]    i_in_rs1,
  input  logic [4:0]    i_in_rs2,
  input  logic [6:0]    i_in_func7,
  input  logic [31:0]   i_in_imm,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [31:0]   o_out_instr,
  output logic [31:0]   o_out_addr,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_fmt_err
);

  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_LAST  = CW'(DEPTH - 1);

  state_t        r_state;
  logic          r_out_valid;
  logic [31:0]   r_out_instr;
  logic [31:0]   r_out_addr;
  logic [31:0]   r_addr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_acc_cnt;
  logic          r_full;
  logic          r_fmt_err;

  logic [31:0]   w_instr;
  logic          w_legal;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_out_hs;

  instr_field_packer u_packer (
    .i_fmt    (i_in_fmt),
    .i_opcode (i_in_opcode),
    .i_rd     (i_in_rd),
    .i_func3  (i_in_func3),
    .i_rs1    (i_in_rs1),
    .i_rs2    (i_in_rs2),
    .i_func7  (i_in_func7),
    .i_imm    (i_in_imm),
    .o_instr  (w_instr),
    .o_legal  (w_legal)
  );

  // Accept while the output register is empty or being drained this cycle
  assign w_in_ready = (r_state == LOAD) && (!r_out_valid || i_out_ready);
  assign w_accept   = i_in_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && i_out_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= LOAD;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0;
      r_out_addr  <= 32'h0;
      r_addr_ptr  <= BASE_ADDR;
      r_count     <= '0;
      r_acc_cnt   <= '0;
      r_full      <= 1'b0;
      r_fmt_err   <= 1'b0;
    end else begin
      r_fmt_err <= 1'b0;
      if (w_out_hs) begin
        r_out_valid <= 1'b0;
        if (r_count != LP_DEPTH) r_count <= r_count + CW'(1);
      end
      // A legal accept overrides the clear above, keeping one word per cycle
      if (w_accept) begin
        if (w_legal) begin
          r_out_valid <= 1'b1;
          r_out_instr <= w_instr;
          r_out_addr  <= r_addr_ptr;
          r_addr_ptr  <= r_addr_ptr + 32'd4;
          r_acc_cnt   <= r_acc_cnt + CW'(1);
        end else begin
          r_fmt_err <= 1'b1;
        end
      end
      case (r_state)
        LOAD: begin
          if (w_accept && w_legal && (r_acc_cnt == LP_LAST)) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_out_hs) begin
            r_state <= FULL;
            r_full  <= 1'b1;
          end
        end
        default: begin
          r_state <= FULL;
          r_full  <= 1'b1;
        end
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_instr = r_out_instr;
  assign o_out_addr  = r_out_addr;
  assign o_count     = r_count;
  assign o_full      = r_full;
  assign o_fmt_err   = r_fmt_err;

endmodule

// File: tb/tb_instr_assembler_writer.sv
// tb/tb_instr_assembler_writer.sv - directed self-checking bench for instr_assembler_writer (DEPTH=4)
module tb_instr_assembler_writer;
  import riscv_enc_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_func3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [6:0]  in_func7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [2:0]  count;
  logic        full;
  logic        fmt_err;

  int n_checks = 0;
  int n_pass   = 0;

  instr_assembler_writer #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_fmt    (in_fmt),
    .i_in_opcode (in_opcode),
    .i_in_rd     (in_rd),
    .i_in_func3  (in_func3),
    .i_in_rs1    (in_rs1),
    .i_in_rs2    (in_rs2),
    .i_in_func7  (in_func7),
    .i_in_imm    (in_imm),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_instr (out_instr),
    .o_out_addr  (out_addr),
    .o_count     (count),
    .o_full      (full),
    .o_fmt_err   (fmt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_fmt    = fmt;
    in_opcode = op;
    in_rd     = rd;
    in_func3  = f3;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_func7  = f7;
    in_imm    = imm;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
    check({tag, "_instr"}, out_instr, 32'h0);
    check({tag, "_addr"},  out_addr, 32'h0);
    check({tag, "_count"}, {29'h0, count}, 32'h0);
    check({tag, "_full"},  {31'h0, full}, 32'h0);
    check({tag, "_ferr"},  {31'h0, fmt_err}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0;
    drive(FMT_R, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0);
    in_valid = 1'b0;
    step(); step();
    check_reset_state("rst");
    reset = 1'b0;
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);

    // add x3,x1,x2 accepted, then stalled by out_ready=0
    drive(FMT_R, OP_R, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
    step();
    check("r_valid", {31'h0, out_valid}, 32'h1);
    check("r_instr", out_instr, 32'h002081B3);
    check("r_addr", out_addr, 32'h0);
    check("stall_in_ready", {31'h0, in_ready}, 32'h0);
    // addi presented while stalled must not be taken
    drive(FMT_I, OP_I, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF);
    step();
    check("hold_instr", out_instr, 32'h002081B3);
    check("hold_addr", out_addr, 32'h0);
    check("hold_count", {29'h0, count}, 32'h0);
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    check("i_instr", out_instr, 32'hFFF00293);
    check("i_addr", out_addr, 32'h4);
    check("i_count", {29'h0, count}, 32'h1);
    drive(FMT_S, OP_S, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'h4);
    step();
    check("s_instr", out_instr, 32'h0020A223);
    check("s_addr", out_addr, 32'h8);
    check("s_valid", {31'h0, out_valid}, 32'h1);
    check("s_count", {29'h0, count}, 32'h2);

    // illegal fmt consumed alongside the sw handshake
    drive(3'd7, OP_R, 5'd1, 3'd0, 5'd1, 5'd1, 7'd0, 32'h0);
    step();
    check("ferr_pulse", {31'h0, fmt_err}, 32'h1);
    check("ferr_no_out", {31'h0, out_valid}, 32'h0);
    check("ferr_count", {29'h0, count}, 32'h3);
    in_valid = 1'b0;
    step();
    check("ferr_clear", {31'h0, fmt_err}, 32'h0);

    // beq x1,x2,-8 is the 4th legal word: address unchanged by the dropped tuple
    drive(FMT_B, OP_B, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFF8);
    step();
    check("b_instr", out_instr, 32'hFE208CE3);
    check("b_addr", out_addr, 32'hC);
    check("drain_in_ready", {31'h0, in_ready}, 32'h0);
    check("drain_full", {31'h0, full}, 32'h0);
    drive(FMT_J, OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h10);
    step();
    check("full_set", {31'h0, full}, 32'h1);
    check("full_count", {29'h0, count}, 32'h4);
    check("full_no_out", {31'h0, out_valid}, 32'h0);
    step();
    check("full_5th_dropped", {31'h0, out_valid}, 32'h0);
    check("full_in_ready", {31'h0, in_ready}, 32'h0);
    check("full_count_sat", {29'h0, count}, 32'h4);

    // restart, then reset while a word is stalled at the output
    reset = 1'b1; in_valid = 1'b0;
    step();
    reset = 1'b0; out_ready = 1'b0;
    drive(FMT_J, OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h10);
    step();
    check("j_instr", out_instr, 32'h010000EF);
    check("j_addr", out_addr, 32'h0);
    in_valid = 1'b0; reset = 1'b1;
    step();
    check_reset_state("midrst");
    reset = 1'b0; out_ready = 1'b1;
    drive(FMT_U, OP_LUI, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
    step();
    check("u_instr", out_instr, 32'h123450B7);
    check("u_addr", out_addr, 32'h0);
    in_valid = 1'b0;
    step();
    check("u_count", {29'h0, count}, 32'h1);
    check("u_drained", {31'h0, out_valid}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
